// File: rtl/lpc_capture_fifo.sv
// Captures completed LPC cycles as 48-bit records, buffers them in a FIFO and
// streams each one out as 6 bytes, MSB first, over a valid/ready byte interface.
module lpc_capture_fifo #(
    parameter int DEPTH = 16
) (
    input  logic        lpc_clock,
    input  logic        lpc_reset,
    input  logic [3:0]  in_cyctype_dir,
    input  logic [31:0] in_addr,
    input  logic [7:0]  in_data,
    input  logic        in_sync_timeout,
    input  logic        in_clock_enable,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        fifo_empty,
    output logic        fifo_full,
    output logic [7:0]  drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    logic [47:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr, r_rptr;
    logic [AW:0]   r_count;
    logic          r_en_prev, r_ovf_pending;
    state_t        r_state;
    logic [47:0]   r_shift;
    logic [2:0]    r_idx;
    logic          r_valid, r_last;
    logic [7:0]    r_drop_count;

    logic          w_push_req, w_push, w_pop, w_empty, w_full;
    logic [47:0]   w_record;

    assign w_push_req = in_clock_enable & ~r_en_prev;
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == FULL_CNT);
    assign w_push     = w_push_req & ~w_full;
    // A load happens from IDLE, or on the handshake of byte 5 for back-to-back records
    assign w_pop      = ~w_empty & ((r_state == S_IDLE) |
                        ((r_state == S_SEND) & out_ready & (r_idx == 3'd5)));
    assign w_record   = {in_sync_timeout, r_ovf_pending, 2'b00, in_cyctype_dir, in_addr, in_data};

    always_ff @(posedge lpc_clock) begin
        if (w_push) r_mem[r_wptr] <= w_record;
    end

    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            r_en_prev     <= 1'b1;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_count       <= '0;
            r_ovf_pending <= 1'b0;
            r_drop_count  <= 8'd0;
        end else begin
            r_en_prev <= in_clock_enable;
            if (w_push) begin
                r_wptr        <= r_wptr + 1'b1;
                r_ovf_pending <= 1'b0;
            end else if (w_push_req) begin
                r_ovf_pending <= 1'b1;
                if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
            end
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_idx   <= 3'd0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shift <= r_mem[r_rptr];
                        r_idx   <= 3'd0;
                        r_valid <= 1'b1;
                        r_last  <= 1'b0;
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (out_ready) begin
                        if (r_idx != 3'd5) begin
                            r_shift <= {r_shift[39:0], 8'h00};
                            r_idx   <= r_idx + 3'd1;
                            r_last  <= (r_idx == 3'd4);
                        end else if (w_pop) begin
                            r_shift <= r_mem[r_rptr];
                            r_idx   <= 3'd0;
                            r_last  <= 1'b0;
                        end else begin
                            r_shift <= '0;
                            r_idx   <= 3'd0;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign out_byte   = r_shift[47:40];
    assign out_valid  = r_valid;
    assign out_last   = r_last;
    assign fifo_empty = w_empty;
    assign fifo_full  = w_full;
    assign drop_count = r_drop_count;
endmodule

// File: tb/tb_lpc_capture_fifo.sv
// Directed bench for lpc_capture_fifo: table of single records, then
// hand-written back-to-back, overflow, saturation and reset sequences.
module tb_lpc_capture_fifo;
    logic        lpc_clock, lpc_reset;
    logic [3:0]  in_cyctype_dir;
    logic [31:0] in_addr;
    logic [7:0]  in_data;
    logic        in_sync_timeout, in_clock_enable;
    logic [7:0]  out_byte;
    logic        out_valid, out_ready, out_last;
    logic        fifo_empty, fifo_full;
    logic [7:0]  drop_count;

    lpc_capture_fifo #(.DEPTH(16)) dut (
        .lpc_clock(lpc_clock), .lpc_reset(lpc_reset),
        .in_cyctype_dir(in_cyctype_dir), .in_addr(in_addr), .in_data(in_data),
        .in_sync_timeout(in_sync_timeout), .in_clock_enable(in_clock_enable),
        .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .drop_count(drop_count)
    );

    initial begin
        lpc_clock = 1'b0;
        forever #5 lpc_clock = ~lpc_clock;
    end

    typedef struct {
        logic [3:0]  ct;
        logic [31:0] addr;
        logic [7:0]  data;
        logic        to;
        bit          bp;
        logic [47:0] exp;
    } vec_t;

    vec_t       vecs [4];
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] got_b [$];
    logic       got_l [$];

    task automatic tick();
        @(negedge lpc_clock);
    endtask

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] ct, input logic [31:0] a, input logic [7:0] d,
                        input logic to, output logic mid_v);
        in_cyctype_dir = ct; in_addr = a; in_data = d; in_sync_timeout = to;
        in_clock_enable = 1'b1;
        tick();
        mid_v = out_valid;
        in_clock_enable = 1'b0;
        tick();
    endtask

    // Gathers n handshaken bytes; bp selects a 1,0,0 repeating ready pattern.
    task automatic collect(input int n, input bit bp, output int cycles);
        int k = 0;
        bit stalled = 0;
        logic [7:0] hb = 8'h00;
        logic hl = 1'b0;
        got_b.delete(); got_l.delete();
        cycles = 0;
        while (got_b.size() < n && cycles < 400) begin
            out_ready = bp ? (k % 3 == 0) : 1'b1;
            k++;
            if (stalled) begin
                chk("stall_valid", 48'(out_valid), 48'd1);
                chk("stall_byte", 48'(out_byte), 48'(hb));
                chk("stall_last", 48'(out_last), 48'(hl));
            end
            if (out_valid && out_ready) begin
                got_b.push_back(out_byte); got_l.push_back(out_last); stalled = 0;
            end else if (out_valid) begin
                stalled = 1; hb = out_byte; hl = out_last;
            end
            tick();
            cycles++;
        end
        out_ready = 1'b0;
        if (got_b.size() < n) chk("collect_timeout", 48'(got_b.size()), 48'(n));
    endtask

    initial begin
        logic mv;
        int cyc;
        logic [47:0] rec;
        vec_t b2b [3];

        vecs[0] = '{4'h2, 32'h0000_0080, 8'h5A, 1'b0, 1'b0, 48'h02_00_00_00_80_5A};
        vecs[1] = '{4'h0, 32'h0000_0064, 8'h00, 1'b1, 1'b0, 48'h80_00_00_00_64_00};
        vecs[2] = '{4'hF, 32'hDEAD_BEEF, 8'hA5, 1'b0, 1'b1, 48'h0F_DE_AD_BE_EF_A5};
        vecs[3] = '{4'h3, 32'h1234_5678, 8'hC3, 1'b1, 1'b1, 48'h83_12_34_56_78_C3};

        lpc_reset = 1'b0; in_clock_enable = 1'b0; out_ready = 1'b0;
        in_cyctype_dir = 4'h0; in_addr = 32'h0; in_data = 8'h0; in_sync_timeout = 1'b0;
        tick(); tick();
        chk("rst_valid", 48'(out_valid), 48'd0);
        chk("rst_last", 48'(out_last), 48'd0);
        chk("rst_byte", 48'(out_byte), 48'd0);
        chk("rst_empty", 48'(fifo_empty), 48'd1);
        chk("rst_full", 48'(fifo_full), 48'd0);
        chk("rst_drops", 48'(drop_count), 48'd0);
        lpc_reset = 1'b1;
        tick();

        // Single records, plain and with backpressure
        for (int v = 0; v < 4; v++) begin
            push(vecs[v].ct, vecs[v].addr, vecs[v].data, vecs[v].to, mv);
            chk("lat_mid_valid", 48'(mv), 48'd0);
            chk("lat_valid", 48'(out_valid), 48'd1);
            collect(6, vecs[v].bp, cyc);
            for (int i = 0; i < 6; i++) begin
                rec = vecs[v].exp;
                chk($sformatf("v%0d_byte%0d", v, i), 48'(got_b[i]), 48'(rec[47-8*i -: 8]));
                chk($sformatf("v%0d_last%0d", v, i), 48'(got_l[i]), 48'(i == 5));
            end
            chk("single_empty", 48'(fifo_empty), 48'd1);
            chk("single_idle", 48'(out_valid), 48'd0);
        end

        // Back-to-back: 3 queued records stream as 18 bytes with no bubble
        b2b[0] = vecs[0]; b2b[1] = vecs[1]; b2b[2] = vecs[3];
        for (int r = 0; r < 3; r++) push(b2b[r].ct, b2b[r].addr, b2b[r].data, b2b[r].to, mv);
        collect(18, 1'b0, cyc);
        chk("b2b_cycles", 48'(cyc), 48'd18);
        for (int i = 0; i < 18; i++) begin
            rec = b2b[i/6].exp;
            chk("b2b_byte", 48'(got_b[i]), 48'(rec[47-8*(i%6) -: 8]));
            chk("b2b_last", 48'(got_l[i]), 48'(i % 6 == 5));
        end

        // Overflow: one record sits in the serializer, 16 fill the FIFO, 3 drop
        for (int i = 0; i < 20; i++) push(4'h1, 32'(i), 8'(i), 1'b0, mv);
        chk("ovf_full", 48'(fifo_full), 48'd1);
        chk("ovf_drops", 48'(drop_count), 48'd3);
        collect(12, 1'b0, cyc);
        chk("ovf_drain_byte0", 48'(got_b[0]), 48'h01);
        chk("ovf_drain_data", 48'(got_b[11]), 48'h01);
        chk("ovf_not_full", 48'(fifo_full), 48'd0);
        push(4'h5, 32'h0000_1000, 8'hAA, 1'b0, mv);
        push(4'h6, 32'h0000_2000, 8'hBB, 1'b0, mv);
        chk("ovf_refull", 48'(fifo_full), 48'd1);
        chk("ovf_drops_hold", 48'(drop_count), 48'd3);
        collect(102, 1'b0, cyc);
        chk("ovf_rec2_byte0", 48'(got_b[0]), 48'h01);
        chk("ovf_rec16_data", 48'(got_b[89]), 48'h10);
        chk("ovf_flag_set", 48'(got_b[90]), 48'h45);
        chk("ovf_flag_data", 48'(got_b[95]), 48'hAA);
        chk("ovf_flag_clr", 48'(got_b[96]), 48'h06);
        chk("ovf_clr_data", 48'(got_b[101]), 48'hBB);
        chk("ovf_empty", 48'(fifo_empty), 48'd1);

        // drop_count saturates at 255
        for (int i = 0; i < 300; i++) push(4'h7, 32'(i), 8'(i), 1'b0, mv);
        chk("sat_drops", 48'(drop_count), 48'd255);
        chk("sat_full", 48'(fifo_full), 48'd1);

        // Reset while byte 2 of a record is on the bus
        out_ready = 1'b1;
        tick(); tick();
        out_ready = 1'b0;
        chk("mid_valid", 48'(out_valid), 48'd1);
        lpc_reset = 1'b0;
        #1;
        chk("arst_valid", 48'(out_valid), 48'd0);
        chk("arst_empty", 48'(fifo_empty), 48'd1);
        chk("arst_drops", 48'(drop_count), 48'd0);
        chk("arst_last", 48'(out_last), 48'd0);
        in_clock_enable = 1'b1;
        out_ready = 1'b1;
        tick();
        lpc_reset = 1'b1;
        tick(); tick(); tick();
        chk("rel_no_capture", 48'(fifo_empty), 48'd1);
        chk("rel_no_valid", 48'(out_valid), 48'd0);
        in_clock_enable = 1'b0;
        tick();
        push(vecs[0].ct, vecs[0].addr, vecs[0].data, vecs[0].to, mv);
        collect(6, 1'b0, cyc);
        for (int i = 0; i < 6; i++) begin
            rec = vecs[0].exp;
            chk("post_rst_byte", 48'(got_b[i]), 48'(rec[47-8*i -: 8]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
